// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue controller: ALU/shift/compare codes,
// RV32I opcodes, FSM state type and the decoded-instruction bundle.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SHIFT = 4'b1111;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_SRL  = 2'b10;
    localparam logic [1:0] SH_SLL  = 2'b11;

    // Compare codes coincide with the branch funct3 field.
    localparam logic [2:0] CMP_BEQ  = 3'b000;
    localparam logic [2:0] CMP_BNE  = 3'b001;
    localparam logic [2:0] CMP_BLT  = 3'b100;
    localparam logic [2:0] CMP_BGE  = 3'b101;
    localparam logic [2:0] CMP_BLTU = 3'b110;
    localparam logic [2:0] CMP_BGEU = 3'b111;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_B = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [3:0]  alu_control;
        logic [1:0]  shift;
        logic [2:0]  compare;
        logic        alu_src;
        logic [31:0] imm;
        logic        is_alu;
        logic        is_branch;
        logic        r_shift;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I subset decode: instruction word to ALU controls,
// immediate and illegal flag.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] inst_i,
    output dec_t        dec_o
);

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i;
    logic [31:0] imm_sh;
    logic [31:0] imm_b;
    logic        unused_rs1;

    assign opcode     = inst_i[6:0];
    assign funct3     = inst_i[14:12];
    assign funct7     = inst_i[31:25];
    assign imm_i      = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_sh     = {27'b0, inst_i[24:20]};
    assign imm_b      = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign unused_rs1 = ^inst_i[19:15];

    always_comb begin
        dec_o         = '0;
        dec_o.illegal = 1'b1;
        case (opcode)
            OP_R: begin
                dec_o.illegal = 1'b0;
                dec_o.is_alu  = 1'b1;
                dec_o.alu_src = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000: dec_o.alu_control = ALU_ADD;
                        3'b111: dec_o.alu_control = ALU_AND;
                        3'b110: dec_o.alu_control = ALU_OR;
                        3'b001: begin
                            dec_o.alu_control = ALU_SHIFT;
                            dec_o.shift       = SH_SLL;
                            dec_o.r_shift     = 1'b1;
                        end
                        3'b101: begin
                            dec_o.alu_control = ALU_SHIFT;
                            dec_o.shift       = SH_SRL;
                            dec_o.r_shift     = 1'b1;
                        end
                        default: dec_o.illegal = 1'b1;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_o.alu_control = ALU_SUB;
                end else begin
                    dec_o.illegal = 1'b1;
                end
            end
            OP_I: begin
                dec_o.illegal = 1'b0;
                dec_o.is_alu  = 1'b1;
                dec_o.imm     = imm_i;
                case (funct3)
                    3'b000: dec_o.alu_control = ALU_ADD;
                    3'b111: dec_o.alu_control = ALU_AND;
                    3'b110: dec_o.alu_control = ALU_OR;
                    3'b001, 3'b101: begin
                        dec_o.alu_control = ALU_SHIFT;
                        dec_o.shift       = funct3[2] ? SH_SRL : SH_SLL;
                        dec_o.imm         = imm_sh;
                        if (funct7 != F7_BASE) dec_o.illegal = 1'b1;
                    end
                    default: dec_o.illegal = 1'b1;
                endcase
            end
            OP_B: begin
                if (funct3[2:1] != 2'b01) begin
                    dec_o.illegal     = 1'b0;
                    dec_o.is_branch   = 1'b1;
                    dec_o.alu_control = ALU_SUB;
                    dec_o.alu_src     = 1'b1;
                    dec_o.compare     = funct3;
                    dec_o.imm         = imm_b;
                end
            end
            default: dec_o.illegal = 1'b1;
        endcase
        // Illegal words leave every control at zero.
        if (dec_o.illegal) begin
            dec_o         = '0;
            dec_o.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue ALU controller: accepts one instruction, drives the external
// ALU for a fixed window, then emits a one-cycle writeback/branch/illegal strobe.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid_i,
    output logic        inst_ready_o,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output logic [3:0]  alu_control_o,
    output logic [1:0]  shift_o,
    output logic [2:0]  compare_o,
    output logic        alu_src_o,
    output logic [31:0] imme_o,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o,
    input  logic [31:0] alu_result_i,
    input  logic        zero_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        br_valid_o,
    output logic        br_taken_o,
    output logic [31:0] br_target_o,
    output logic        illegal_o
);

    dec_t   dec;
    state_t state;
    logic   is_alu_q;
    logic   is_br_q;
    logic   accept;

    alu_decode u_decode (
        .inst_i (inst_i),
        .dec_o  (dec)
    );

    assign accept = (state == ST_IDLE) && inst_ready_o && inst_valid_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            inst_ready_o  <= 1'b0;
            alu_control_o <= '0;
            shift_o       <= '0;
            compare_o     <= '0;
            alu_src_o     <= 1'b0;
            imme_o        <= '0;
            rdata1_o      <= '0;
            rdata2_o      <= '0;
            wb_valid_o    <= 1'b0;
            wb_rd_o       <= '0;
            wb_data_o     <= '0;
            br_valid_o    <= 1'b0;
            br_taken_o    <= 1'b0;
            br_target_o   <= '0;
            illegal_o     <= 1'b0;
            is_alu_q      <= 1'b0;
            is_br_q       <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            br_valid_o <= 1'b0;
            br_taken_o <= 1'b0;
            illegal_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    inst_ready_o <= 1'b1;
                    if (accept) begin
                        inst_ready_o  <= 1'b0;
                        alu_control_o <= dec.alu_control;
                        shift_o       <= dec.shift;
                        compare_o     <= dec.compare;
                        alu_src_o     <= dec.alu_src;
                        imme_o        <= dec.imm;
                        is_alu_q      <= dec.is_alu;
                        is_br_q       <= dec.is_branch;
                        wb_rd_o       <= dec.is_alu ? inst_i[11:7] : 5'd0;
                        br_target_o   <= dec.is_branch ? pc_i + dec.imm : 32'd0;
                        if (dec.illegal) begin
                            rdata1_o  <= '0;
                            rdata2_o  <= '0;
                            illegal_o <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            rdata1_o <= rs1_data_i;
                            rdata2_o <= dec.r_shift ? {27'b0, rs2_data_i[4:0]} : rs2_data_i;
                            state    <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    // ALU result has settled by now; capture it on the way into DONE.
                    wb_data_o  <= alu_result_i;
                    wb_valid_o <= is_alu_q && (wb_rd_o != 5'd0);
                    br_valid_o <= is_br_q;
                    br_taken_o <= is_br_q && zero_i;
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    inst_ready_o <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed plus randomized bench for alu_issue_ctrl against a field-level
// reference model of the supported RV32I subset.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_valid_i = 1'b0;
    logic        inst_ready_o;
    logic [31:0] inst_i = '0, pc_i = '0, rs1_data_i = '0, rs2_data_i = '0;
    logic [3:0]  alu_control_o;
    logic [1:0]  shift_o;
    logic [2:0]  compare_o;
    logic        alu_src_o;
    logic [31:0] imme_o, rdata1_o, rdata2_o;
    logic [31:0] alu_result_i = '0;
    logic        zero_i = 1'b0;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        br_valid_o, br_taken_o;
    logic [31:0] br_target_o;
    logic        illegal_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
        .inst_i(inst_i), .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .alu_control_o(alu_control_o), .shift_o(shift_o), .compare_o(compare_o),
        .alu_src_o(alu_src_o), .imme_o(imme_o), .rdata1_o(rdata1_o), .rdata2_o(rdata2_o),
        .alu_result_i(alu_result_i), .zero_i(zero_i),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .br_valid_o(br_valid_o), .br_taken_o(br_taken_o), .br_target_o(br_target_o),
        .illegal_o(illegal_o)
    );

    // Expected values from the reference model
    logic        e_legal, e_src, e_isalu, e_isbr;
    logic [3:0]  e_ctl;
    logic [1:0]  e_sh;
    logic [2:0]  e_cmp;
    logic [31:0] e_imm, e_r1, e_r2, e_tgt;
    logic [4:0]  e_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [31:0] w, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        logic [6:0] opc, f7;
        logic [2:0] f3;
        int         boff;
        opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        e_legal = 0; e_src = 0; e_isalu = 0; e_isbr = 0;
        e_ctl = 0; e_sh = 0; e_cmp = 0; e_imm = 0;
        e_r1 = rs1; e_r2 = rs2; e_rd = w[11:7]; e_tgt = 0;
        if (opc == 7'h33) begin
            e_src = 1; e_isalu = 1;
            if (f7 == 7'h00 && f3 == 3'd0) begin e_legal = 1; e_ctl = 4'b0010; end
            if (f7 == 7'h20 && f3 == 3'd0) begin e_legal = 1; e_ctl = 4'b0110; end
            if (f7 == 7'h00 && f3 == 3'd7) begin e_legal = 1; e_ctl = 4'b0000; end
            if (f7 == 7'h00 && f3 == 3'd6) begin e_legal = 1; e_ctl = 4'b0001; end
            if (f7 == 7'h00 && f3 == 3'd1) begin e_legal = 1; e_ctl = 4'b1111; e_sh = 2'b11; e_r2 = rs2 % 32; end
            if (f7 == 7'h00 && f3 == 3'd5) begin e_legal = 1; e_ctl = 4'b1111; e_sh = 2'b10; e_r2 = rs2 % 32; end
        end else if (opc == 7'h13) begin
            e_isalu = 1;
            e_imm = 32'($signed(w[31:20]));
            if (f3 == 3'd0) begin e_legal = 1; e_ctl = 4'b0010; end
            if (f3 == 3'd7) begin e_legal = 1; e_ctl = 4'b0000; end
            if (f3 == 3'd6) begin e_legal = 1; e_ctl = 4'b0001; end
            if (f7 == 7'h00 && f3 == 3'd1) begin e_legal = 1; e_ctl = 4'b1111; e_sh = 2'b11; e_imm = 32'(w[24:20]); end
            if (f7 == 7'h00 && f3 == 3'd5) begin e_legal = 1; e_ctl = 4'b1111; e_sh = 2'b10; e_imm = 32'(w[24:20]); end
        end else if (opc == 7'h63 && f3 != 3'd2 && f3 != 3'd3) begin
            e_legal = 1; e_isbr = 1; e_src = 1; e_ctl = 4'b0110;
            case (f3)
                3'd0: e_cmp = 3'b000;
                3'd1: e_cmp = 3'b001;
                3'd4: e_cmp = 3'b100;
                3'd5: e_cmp = 3'b101;
                3'd6: e_cmp = 3'b110;
                default: e_cmp = 3'b111;
            endcase
            boff = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            e_imm = 32'(boff);
            e_tgt = pc + e_imm;
        end
        if (!e_legal) begin
            e_src = 0; e_isalu = 0; e_isbr = 0; e_ctl = 0; e_sh = 0; e_cmp = 0;
            e_imm = 0; e_r1 = 0; e_r2 = 0;
        end
    endtask

    task automatic chk_alu(input string tag);
        chk({tag, ".ctl"},  32'(alu_control_o), 32'(e_ctl));
        chk({tag, ".sh"},   32'(shift_o),       32'(e_sh));
        chk({tag, ".cmp"},  32'(compare_o),     32'(e_cmp));
        chk({tag, ".src"},  32'(alu_src_o),     32'(e_src));
        chk({tag, ".imm"},  imme_o,             e_imm);
        chk({tag, ".rd1"},  rdata1_o,           e_r1);
        chk({tag, ".rd2"},  rdata2_o,           e_r2);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        @(negedge clk);
        while (!inst_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".ready_timeout"}, 32'(inst_ready_o), 32'd1);
    endtask

    task automatic run_inst(input string tag, input logic [31:0] w, input logic [31:0] pc,
                            input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic [31:0] res, input logic z);
        logic exp_wb;
        model(w, pc, rs1, rs2);
        wait_ready(tag);
        inst_valid_i = 1; inst_i = w; pc_i = pc; rs1_data_i = rs1; rs2_data_i = rs2;
        @(posedge clk); #1;
        inst_valid_i = 0; inst_i = $urandom; pc_i = $urandom;
        rs1_data_i = $urandom; rs2_data_i = $urandom;
        chk_alu({tag, ".e0"});
        chk({tag, ".e0.ready"}, 32'(inst_ready_o), 32'd0);
        if (!e_legal) begin
            chk({tag, ".ill"},      32'(illegal_o), 32'd1);
            chk({tag, ".ill.wbbr"}, 32'({wb_valid_o, br_valid_o}), 32'd0);
            @(posedge clk); #1;
            chk({tag, ".ill.off"},   32'(illegal_o), 32'd0);
            chk({tag, ".ill.ready"}, 32'(inst_ready_o), 32'd1);
            return;
        end
        chk({tag, ".e0.strb"}, 32'({wb_valid_o, br_valid_o, illegal_o}), 32'd0);
        @(negedge clk);
        alu_result_i = $urandom; zero_i = 1'($urandom);
        @(posedge clk); #1;
        chk({tag, ".e1.strb"}, 32'({wb_valid_o, br_valid_o, illegal_o}), 32'd0);
        chk_alu({tag, ".e1"});
        @(negedge clk);
        alu_result_i = res; zero_i = z;
        @(posedge clk); #1;
        alu_result_i = ~res; zero_i = ~z;
        exp_wb = e_isalu && (e_rd != 0);
        chk({tag, ".wbv"}, 32'(wb_valid_o), 32'(exp_wb));
        if (exp_wb) begin
            chk({tag, ".wbrd"},   32'(wb_rd_o), 32'(e_rd));
            chk({tag, ".wbdata"}, wb_data_o,    res);
        end
        chk({tag, ".brv"}, 32'(br_valid_o), 32'(e_isbr));
        if (e_isbr) begin
            chk({tag, ".brtk"},  32'(br_taken_o), 32'(z));
            chk({tag, ".brtgt"}, br_target_o,     e_tgt);
        end
        chk({tag, ".e2.ill"},   32'(illegal_o), 32'd0);
        chk({tag, ".e2.ready"}, 32'(inst_ready_o), 32'd0);
        chk_alu({tag, ".e2"});
        @(posedge clk); #1;
        chk({tag, ".e3.strb"},  32'({wb_valid_o, br_valid_o, br_taken_o, illegal_o}), 32'd0);
        chk({tag, ".e3.ready"}, 32'(inst_ready_o), 32'd1);
    endtask

    function automatic logic [6:0] pick_f7();
        int r = $urandom % 4;
        if (r == 0) return 7'($urandom);
        if (r == 1) return 7'h20;
        return 7'h00;
    endfunction

    initial begin
        logic [31:0] w, held_rs1;
        int          acc;
        logic        acc_now;

        // Reset state
        #12;
        chk("rst.ready", 32'(inst_ready_o), 32'd0);
        chk("rst.outs", 32'(|{alu_control_o, shift_o, compare_o, alu_src_o, imme_o, rdata1_o,
                              rdata2_o, wb_valid_o, wb_rd_o, wb_data_o, br_valid_o,
                              br_taken_o, br_target_o, illegal_o}), 32'd0);
        @(negedge clk); rst_n = 1;
        #1 chk("rst.rel.ready", 32'(inst_ready_o), 32'd0);
        @(posedge clk); #1;
        chk("rst.first_edge.ready", 32'(inst_ready_o), 32'd1);

        // Directed cases
        run_inst("addi", 32'hFFD00293, 32'h0, 32'h1234, 32'h5678, 32'hFFFFFFFD, 1'b0);
        run_inst("bne",  32'h00209863, 32'h100, 32'h7, 32'h9, 32'h0, 1'b1);
        run_inst("sll",  32'h002091B3, 32'h0, 32'hAAAA5555, 32'h00000023, 32'h55550000, 1'b0);
        run_inst("illegal0", 32'h00000000, 32'h40, 32'h1, 32'h2, 32'h0, 1'b0);
        run_inst("add_x0", 32'h00208033, 32'h0, 32'h1, 32'h2, 32'h3, 1'b0);
        run_inst("srai_ill", 32'h40315093, 32'h0, 32'h1, 32'h2, 32'h0, 1'b0);
        run_inst("beq_neg", 32'hFE208EE3, 32'h200, 32'h5, 32'h5, 32'h0, 1'b1);

        // Reset during WAIT aborts silently
        wait_ready("rstwait");
        inst_valid_i = 1; inst_i = 32'h00500093; rs1_data_i = 32'h11; rs2_data_i = 32'h22;
        @(posedge clk); #1; inst_valid_i = 0;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("rstwait.outs", 32'(|{inst_ready_o, alu_control_o, shift_o, compare_o, alu_src_o,
                                  imme_o, rdata1_o, rdata2_o, wb_valid_o, wb_rd_o, wb_data_o,
                                  br_valid_o, br_taken_o, br_target_o, illegal_o}), 32'd0);
        @(posedge clk); #1;
        chk("rstwait.hold", 32'({wb_valid_o, br_valid_o, illegal_o, inst_ready_o}), 32'd0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        chk("rstwait.strb", 32'({wb_valid_o, br_valid_o, illegal_o}), 32'd0);
        chk("rstwait.ready", 32'(inst_ready_o), 32'd1);
        run_inst("after_rst", 32'h00A00113, 32'h0, 32'h0, 32'h0, 32'h0000000A, 1'b0);

        // Randomized instructions
        for (int i = 0; i < 40; i++) begin
            w = $urandom;
            case ($urandom % 4)
                0: begin w[6:0] = 7'h33; w[31:25] = pick_f7(); end
                1: begin w[6:0] = 7'h13; w[31:25] = pick_f7(); end
                2: w[6:0] = 7'h63;
                default: ;
            endcase
            run_inst($sformatf("rnd%0d", i), w, $urandom, $urandom, $urandom, $urandom, 1'($urandom));
        end

        // Back-to-back offers: one acceptance per 4 cycles, operands held
        wait_ready("b2b");
        inst_valid_i = 1; inst_i = 32'h00308093;
        acc = 0; held_rs1 = 0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            rs1_data_i = $urandom; pc_i = $urandom; alu_result_i = $urandom;
            acc_now = inst_ready_o;
            if (acc_now) begin
                acc++;
                held_rs1 = rs1_data_i;
            end
            @(posedge clk); #1;
            chk($sformatf("b2b.rd1.c%0d", c), rdata1_o, held_rs1);
        end
        inst_valid_i = 0;
        chk("b2b.accepts", 32'(acc), 32'd10);
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
